pc_fetch_unit: RTL and testbench

//  Parametrised PC generator and fetch stage. Owns the architectural fetch PC.

---
 rtl/pc_fetch_unit_if.sv | 29 ++
 rtl/pc_fetch_unit.sv | 156 +++++++++++++++
 tb/tb_pc_fetch_unit.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: instruction memory port, decode handshake, execute redirect and trap report.
// master = fetch unit side, slave = surrounding pipeline/memory side.
interface pc_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned INSTR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic                   redirect_valid;
    logic [1:0]             redirect_op;
    logic [ADDR_WIDTH-1:0]  redirect_base;
    logic [ADDR_WIDTH-1:0]  redirect_offset;
    logic                   misalign_trap;
    logic [ADDR_WIDTH-1:0]  trap_addr;

    modport master (
        output imem_addr, out_valid, out_pc, out_instr, misalign_trap, trap_addr,
        input  imem_rdata, out_ready, redirect_valid, redirect_op, redirect_base, redirect_offset
    );

    modport slave (
        input  imem_addr, out_valid, out_pc, out_instr, misalign_trap, trap_addr,
        output imem_rdata, out_ready, redirect_valid, redirect_op, redirect_base, redirect_offset
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// PC generator and fetch stage with a small prefetch queue drained by decode.
// Optional macro FETCH_MISALIGN_TRAP_EN: halt fetch on misaligned redirect targets.
module pc_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int unsigned           QUEUE_DEPTH = 2,
    parameter int unsigned           PC_STEP     = 4
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_TRAP = 1'b1} state_t;

    state_t                  state_r, state_s;
    logic [ADDR_WIDTH-1:0]   fetch_pc_r, fetch_pc_s;
    logic [ADDR_WIDTH-1:0]   target_s;
    logic                    misaligned_s;
    logic                    misalign_trap_r, misalign_trap_s;
    logic [ADDR_WIDTH-1:0]   trap_addr_r, trap_addr_s;
    logic [ADDR_WIDTH-1:0]   q_pc_r    [QUEUE_DEPTH];
    logic [INSTR_WIDTH-1:0]  q_instr_r [QUEUE_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_r, wr_ptr_r;
    logic [CNT_W-1:0]        count_r;
    logic                    valid_s, full_s, enq_s, deq_s, flush_s;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign valid_s = (count_r != '0);
    assign full_s  = (count_r == FULL_CNT);

    // Redirect target computation and alignment handling.
    always_comb begin
        target_s = RESET_PC;
        case (bus.redirect_op)
            2'b00:   target_s = RESET_PC;
            2'b01:   target_s = bus.redirect_base + bus.redirect_offset;
            2'b10:   target_s = bus.redirect_offset;
            2'b11:   target_s = bus.redirect_offset & ~ADDR_WIDTH'(1'b1);
            default: target_s = RESET_PC;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned_s = (target_s[1:0] != 2'b00);
`else
        target_s     = {target_s[ADDR_WIDTH-1:2], 2'b00};
        misaligned_s = 1'b0;
`endif
    end

    // Next-state, queue control and fetch PC; redirect overrides everything.
    always_comb begin
        state_s         = state_r;
        fetch_pc_s      = fetch_pc_r;
        misalign_trap_s = misalign_trap_r;
        trap_addr_s     = trap_addr_r;
        enq_s           = 1'b0;
        deq_s           = 1'b0;
        flush_s         = 1'b0;
        if (bus.redirect_valid) begin
            flush_s    = 1'b1;
            fetch_pc_s = target_s;
            if (misaligned_s) begin
                state_s         = ST_TRAP;
                misalign_trap_s = 1'b1;
                trap_addr_s     = target_s;
            end else begin
                state_s         = ST_RUN;
                misalign_trap_s = 1'b0;
                trap_addr_s     = '0;
            end
        end else begin
            deq_s = valid_s && bus.out_ready;
            case (state_r)
                ST_RUN: begin
                    if (!full_s || deq_s) begin
                        enq_s      = 1'b1;
                        fetch_pc_s = fetch_pc_r + STEP;
                    end else begin
                        enq_s      = 1'b0;
                    end
                end
                ST_TRAP: enq_s   = 1'b0;
                default: state_s = ST_RUN;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_s;
        end
    end

    // Fetch PC, trap report and prefetch queue storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r      <= RESET_PC;
            misalign_trap_r <= 1'b0;
            trap_addr_r     <= '0;
            rd_ptr_r        <= '0;
            wr_ptr_r        <= '0;
            count_r         <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_pc_r[i]    <= '0;
                q_instr_r[i] <= '0;
            end
        end else begin
            fetch_pc_r      <= fetch_pc_s;
            misalign_trap_r <= misalign_trap_s;
            trap_addr_r     <= trap_addr_s;
            if (flush_s) begin
                rd_ptr_r <= '0;
                wr_ptr_r <= '0;
                count_r  <= '0;
            end else begin
                if (enq_s) begin
                    q_pc_r[wr_ptr_r]    <= fetch_pc_r;
                    q_instr_r[wr_ptr_r] <= bus.imem_rdata;
                    wr_ptr_r            <= ptr_inc(wr_ptr_r);
                end
                if (deq_s) begin
                    rd_ptr_r <= ptr_inc(rd_ptr_r);
                end
                case ({enq_s, deq_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    assign bus.imem_addr     = fetch_pc_r;
    assign bus.out_valid     = valid_s;
    assign bus.out_pc        = q_pc_r[rd_ptr_r];
    assign bus.out_instr     = q_instr_r[rd_ptr_r];
    assign bus.misalign_trap = misalign_trap_r;
    assign bus.trap_addr     = trap_addr_r;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: expected {pc, instr} pairs are queued as
// stimulus is applied and popped whenever decode accepts an entry.
module tb_pc_fetch_unit;
    logic clk;
    logic reset;
    int   errors;
    int   checks;
    logic [31:0] exp_q[$];

    pc_fetch_unit_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    pc_fetch_unit #(
        .ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0000_0000),
        .QUEUE_DEPTH(2), .PC_STEP(4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: word at byte address a holds a>>2.
    assign bus.imem_rdata = {2'b00, bus.imem_addr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: score any accepted head at the falling edge, return just after the rising edge.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=pc_%h expected=no_output", bus.out_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_pc", bus.out_pc, e);
                chk("out_instr", bus.out_instr, {2'b00, e[31:2]});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [1:0] op, input logic [31:0] base, input logic [31:0] off);
        bus.redirect_valid  = 1'b1;
        bus.redirect_op     = op;
        bus.redirect_base   = base;
        bus.redirect_offset = off;
        tick();
        bus.redirect_valid  = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.out_ready       = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_op     = 2'b00;
        bus.redirect_base   = 32'h0;
        bus.redirect_offset = 32'h0;

        #2;
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_out_pc", bus.out_pc, 32'h0);
        chk("rst_out_instr", bus.out_instr, 32'h0);
        chk("rst_trap", {31'b0, bus.misalign_trap}, 32'h0);
        chk("rst_trap_addr", bus.trap_addr, 32'h0);

        // Sequential fetch from reset, one per cycle.
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
        chk("t1_valid_at_release", {31'b0, bus.out_valid}, 32'h0);
        tick();
        chk("t1_first_valid", {31'b0, bus.out_valid}, 32'h1);
        for (int i = 0; i < 8; i++) tick();
        chk("t1_drained", 32'(exp_q.size()), 32'h0);

        // Back-pressure: queue fills, fetch PC holds, then drains without gaps.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("t2_valid_held", {31'b0, bus.out_valid}, 32'h1);
        chk("t2_head_pc", bus.out_pc, 32'h20);
        chk("t2_fetch_pc_held", bus.imem_addr, 32'h28);
        bus.out_ready = 1'b1;
        exp_q.push_back(32'h20);
        exp_q.push_back(32'h24);
        exp_q.push_back(32'h28);
        for (int i = 0; i < 3; i++) begin
            chk("t2_no_gap", {31'b0, bus.out_valid}, 32'h1);
            tick();
        end
        chk("t2_drained", 32'(exp_q.size()), 32'h0);

        // REL redirect with ready high: stale 0x2C/0x30 entries must vanish.
        redirect(2'b01, 32'h10, 32'h20);
        chk("t3_flushed", {31'b0, bus.out_valid}, 32'h0);
        chk("t3_fetch_pc", bus.imem_addr, 32'h30);
        exp_q.push_back(32'h30);
        exp_q.push_back(32'h34);
        exp_q.push_back(32'h38);
        for (int i = 0; i < 4; i++) tick();
        chk("t3_drained", 32'(exp_q.size()), 32'h0);

        // PC wrap at the top of the address space.
        redirect(2'b10, 32'h0, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 4; i++) tick();
        chk("t4_drained", 32'(exp_q.size()), 32'h0);

        // Misaligned JALR target.
        redirect(2'b11, 32'h0, 32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t5_trap", {31'b0, bus.misalign_trap}, 32'h1);
        chk("t5_trap_addr", bus.trap_addr, 32'h102);
        chk("t5_fetch_pc", bus.imem_addr, 32'h102);
        tick();
        tick();
        chk("t5_no_enqueue", {31'b0, bus.out_valid}, 32'h0);
        redirect(2'b00, 32'h0, 32'h0);
        chk("t5_trap_clr", {31'b0, bus.misalign_trap}, 32'h0);
        chk("t5_trap_addr_clr", bus.trap_addr, 32'h0);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
`else
        chk("t5_trap", {31'b0, bus.misalign_trap}, 32'h0);
        chk("t5_trap_addr", bus.trap_addr, 32'h0);
        chk("t5_fetch_pc", bus.imem_addr, 32'h100);
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
`endif
        for (int i = 0; i < 3; i++) tick();
        chk("t5_drained", 32'(exp_q.size()), 32'h0);

        // Reset asserted between edges with a full queue.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_full_valid", {31'b0, bus.out_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_async_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("t6_async_imem_addr", bus.imem_addr, 32'h0);
        chk("t6_async_out_pc", bus.out_pc, 32'h0);
        chk("t6_async_out_instr", bus.out_instr, 32'h0);
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        for (int i = 0; i < 3; i++) tick();
        chk("t6_drained", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
